alu_arbiter: RTL

Shares the single core ALU between two requesters: port 0 is the execute stage and port 1 is the address-generation/CSR unit. A valid/ready handshake arbitrates round-robin and drives the granted operands onto the ALU. The combinational ALU result is captured into a one-entry response register, which is returned to the issuing requester through its own valid/ready response channel.

---
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/alu_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU-drive and response signals shared by the
// two requesters, the arbiter and the core ALU instance.
// The slave modport is the arbiter's view; the master modport is the view of
// whatever drives requests, returns ALU results and consumes responses.
interface alu_arbiter_if #(
  parameter int XLEN = 64
);
  logic [1:0]      i_ReqValid;
  logic [1:0]      o_ReqReady;
  logic [3:0]      i_ReqALUctl0;
  logic [3:0]      i_ReqALUctl1;
  logic [XLEN-1:0] i_ReqRs1_0;
  logic [XLEN-1:0] i_ReqRs1_1;
  logic [XLEN-1:0] i_ReqRs2_0;
  logic [XLEN-1:0] i_ReqRs2_1;
  logic [XLEN-1:0] i_ReqImm0;
  logic [XLEN-1:0] i_ReqImm1;
  logic            i_ReqALUsrc0;
  logic            i_ReqALUsrc1;
  logic [3:0]      o_ALUctl;
  logic [XLEN-1:0] o_Rs1;
  logic [XLEN-1:0] o_Rs2;
  logic [XLEN-1:0] o_Immediate;
  logic            o_ALUsrc;
  logic [XLEN-1:0] i_Result;
  logic [1:0]      o_RspValid;
  logic [1:0]      i_RspReady;
  logic [XLEN-1:0] o_RspResult;
  logic            o_RspZero;

  modport slave (
    input  i_ReqValid, i_ReqALUctl0, i_ReqALUctl1,
           i_ReqRs1_0, i_ReqRs1_1, i_ReqRs2_0, i_ReqRs2_1,
           i_ReqImm0, i_ReqImm1, i_ReqALUsrc0, i_ReqALUsrc1,
           i_Result, i_RspReady,
    output o_ReqReady, o_ALUctl, o_Rs1, o_Rs2, o_Immediate, o_ALUsrc,
           o_RspValid, o_RspResult, o_RspZero
  );

  modport master (
    output i_ReqValid, i_ReqALUctl0, i_ReqALUctl1,
           i_ReqRs1_0, i_ReqRs1_1, i_ReqRs2_0, i_ReqRs2_1,
           i_ReqImm0, i_ReqImm1, i_ReqALUsrc0, i_ReqALUsrc1,
           i_Result, i_RspReady,
    input  o_ReqReady, o_ALUctl, o_Rs1, o_Rs2, o_Immediate, o_ALUsrc,
           o_RspValid, o_RspResult, o_RspZero
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares the core ALU between the execute stage (requester 0)
// and the address-generation/CSR unit (requester 1). Round-robin grant,
// combinational operand mux to the ALU, one-entry response register.
// Optional performance counters are enabled with `define ALU_ARB_PERF_EN.
module alu_arbiter #(
  parameter int XLEN = 64
`ifdef ALU_ARB_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  alu_arbiter_if.slave    bus
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] o_OpCount,
  output logic [CNT_W-1:0] o_ConflictCount
`endif
);

  logic            rr_last;
  logic            rsp_busy;
  logic            rsp_id;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;
  logic [1:0]      grant;
  logic [1:0]      req_ready;
  logic [1:0]      accept;
  logic            slot_free;
  logic            acc_any;
  logic            acc_id;

  // Round-robin grant: a lone requester wins, contention goes to the one not served last.
  always_comb begin
    grant = bus.i_ReqValid;
    if (bus.i_ReqValid == 2'b11) begin
      grant = rr_last ? 2'b01 : 2'b10;
    end
  end

  // The response slot can take a new result if empty or being drained this cycle.
  assign slot_free      = ~rsp_busy | bus.i_RspReady[rsp_id];
  assign req_ready      = (slot_free & ~i_Rst) ? grant : 2'b00;
  assign accept         = bus.i_ReqValid & req_ready;
  assign acc_any        = |accept;
  assign acc_id         = accept[1];
  assign bus.o_ReqReady = req_ready;

  // Operand mux: granted requester drives the ALU; idle drives the ALU default op.
  always_comb begin
    bus.o_ALUctl    = 4'hF;
    bus.o_Rs1       = '0;
    bus.o_Rs2       = '0;
    bus.o_Immediate = '0;
    bus.o_ALUsrc    = 1'b0;
    if (grant == 2'b01) begin
      bus.o_ALUctl    = bus.i_ReqALUctl0;
      bus.o_Rs1       = bus.i_ReqRs1_0;
      bus.o_Rs2       = bus.i_ReqRs2_0;
      bus.o_Immediate = bus.i_ReqImm0;
      bus.o_ALUsrc    = bus.i_ReqALUsrc0;
    end else if (grant == 2'b10) begin
      bus.o_ALUctl    = bus.i_ReqALUctl1;
      bus.o_Rs1       = bus.i_ReqRs1_1;
      bus.o_Rs2       = bus.i_ReqRs2_1;
      bus.o_Immediate = bus.i_ReqImm1;
      bus.o_ALUsrc    = bus.i_ReqALUsrc1;
    end
  end

  // Response register: reload on accept (even while draining), otherwise clear on completion.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rr_last    <= 1'b1;
      rsp_busy   <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (acc_any) begin
      rr_last    <= acc_id;
      rsp_busy   <= 1'b1;
      rsp_id     <= acc_id;
      rsp_result <= bus.i_Result;
      rsp_zero   <= (bus.i_Result == '0);
    end else if (rsp_busy && bus.i_RspReady[rsp_id]) begin
      rsp_busy   <= 1'b0;
    end
  end

  assign bus.o_RspValid  = rsp_busy ? (rsp_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_RspResult = rsp_result;
  assign bus.o_RspZero   = rsp_zero;

`ifdef ALU_ARB_PERF_EN
  // Performance counters: accepted operations and cycles with both requesters waiting.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_OpCount       <= '0;
      o_ConflictCount <= '0;
    end else begin
      if (acc_any) begin
        o_OpCount <= o_OpCount + 1'b1;
      end
      if (bus.i_ReqValid == 2'b11) begin
        o_ConflictCount <= o_ConflictCount + 1'b1;
      end
    end
  end
`endif

endmodule
